// File: rtl/qspi_pad_arb_pkg.sv
// Shared types and pad park values for the QSPI pad arbiter.
package qspi_pad_arb_pkg;

  localparam int unsigned LANE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2,
    ST_TURN   = 2'd3
  } state_t;

  localparam logic              PARK_SCLK = 1'b0;
  localparam logic [LANE_W-1:0] PARK_CSN  = 4'hF;
  localparam logic [LANE_W-1:0] PARK_SDO  = 4'h0;
  localparam logic [LANE_W-1:0] PARK_OE   = 4'h0;

endpackage

// File: rtl/qspi_pad_arb_rr_arb2.sv
// Two-requester round-robin picker; ptr names the master favoured on a tie.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       winner,
  output logic       valid
);

  always_comb begin
    valid  = |req;
    winner = ptr;
    if (req == 2'b01)
      winner = 1'b0;
    else if (req == 2'b10)
      winner = 1'b1;
  end

endmodule

// File: rtl/qspi_pad_arb.sv
// Time-multiplexes one QSPI pad group between two masters with round-robin
// grants, a parked turnaround gap and an optional hold limit.
module qspi_pad_arb
  import qspi_pad_arb_pkg::*;
#(
  parameter int unsigned TURN_CYC = 2,
  parameter int unsigned HOLD_MAX = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  input  logic [1:0] m_sclk_i,
  input  logic [7:0] m_csn_i,
  input  logic [7:0] m_sdo_i,
  input  logic [7:0] m_oe_i,
  output logic [7:0] m_sdi_o,
  output logic       pad_sclk_o,
  output logic [3:0] pad_csn_o,
  output logic [3:0] pad_sdo_o,
  output logic [3:0] pad_oe_o,
  input  logic [3:0] pad_sdi_i,
  output logic       owner_o,
  output logic       busy_o,
  output logic       err_o
);

  localparam int unsigned HOLD_W = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_MAX);
  localparam logic [3:0] TURN_LAST = 4'(TURN_CYC - 1);
  localparam logic HOLD_EN = (HOLD_MAX != 0);

  state_t            state;
  logic              owner_q;
  logic              prio_q;
  logic [3:0]        turn_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              err_q;

  logic              granted;
  logic              own;
  logic              own_req;
  logic              oth_req;
  logic [3:0]        own_csn;
  logic              force_rel;
  logic              arb_win;
  logic              arb_vld;

  rr_arb2 u_rr (
    .req    (req_i),
    .ptr    (prio_q),
    .winner (arb_win),
    .valid  (arb_vld)
  );

  assign granted   = (state == ST_GRANT0) || (state == ST_GRANT1);
  assign own       = (state == ST_GRANT1);
  assign own_req   = own ? req_i[1] : req_i[0];
  assign oth_req   = own ? req_i[0] : req_i[1];
  assign own_csn   = own ? m_csn_i[7:4] : m_csn_i[3:0];
  // Forced release only at a CS boundary so no transfer is cut mid-frame.
  assign force_rel = HOLD_EN && (hold_cnt >= HOLD_LIM) && oth_req && (own_csn == PARK_CSN);

  assign gnt_o   = {state == ST_GRANT1, state == ST_GRANT0};
  assign owner_o = owner_q;
  assign busy_o  = (state != ST_IDLE);
  assign err_o   = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      owner_q  <= 1'b0;
      prio_q   <= 1'b0;
      turn_cnt <= '0;
      hold_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_vld) begin
            state    <= arb_win ? ST_GRANT1 : ST_GRANT0;
            owner_q  <= arb_win;
            prio_q   <= ~arb_win;
            hold_cnt <= '0;
          end
        end
        ST_GRANT0, ST_GRANT1: begin
          if (!own_req || force_rel) begin
            state    <= ST_TURN;
            turn_cnt <= '0;
          end
          if (oth_req && (hold_cnt < HOLD_LIM))
            hold_cnt <= hold_cnt + 1'b1;
          if (!own_req && (own_csn != PARK_CSN))
            err_q <= 1'b1;
        end
        ST_TURN: begin
          if (turn_cnt == TURN_LAST)
            state <= ST_IDLE;
          else
            turn_cnt <= turn_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
      if (gnt_o == 2'b11)
        err_q <= 1'b1;
    end
  end

  always_comb begin
    pad_sclk_o = PARK_SCLK;
    pad_csn_o  = PARK_CSN;
    pad_sdo_o  = PARK_SDO;
    pad_oe_o   = PARK_OE;
    m_sdi_o    = '0;
    if (granted) begin
      pad_csn_o = own_csn;
      if (own) begin
        pad_sclk_o   = m_sclk_i[1];
        pad_sdo_o    = m_sdo_i[7:4];
        pad_oe_o     = m_oe_i[7:4];
        m_sdi_o[7:4] = pad_sdi_i;
      end else begin
        pad_sclk_o   = m_sclk_i[0];
        pad_sdo_o    = m_sdo_i[3:0];
        pad_oe_o     = m_oe_i[3:0];
        m_sdi_o[3:0] = pad_sdi_i;
      end
    end
  end

endmodule

// File: tb/tb_qspi_pad_arb.sv
// Directed self-checking bench for qspi_pad_arb (TURN_CYC=2, HOLD_MAX=8).
module tb_qspi_pad_arb;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [1:0] req_i = '0;
  logic [1:0] gnt_o;
  logic [1:0] m_sclk_i = '0;
  logic [7:0] m_csn_i = 8'hFF;
  logic [7:0] m_sdo_i = '0;
  logic [7:0] m_oe_i = '0;
  logic [7:0] m_sdi_o;
  logic       pad_sclk_o;
  logic [3:0] pad_csn_o;
  logic [3:0] pad_sdo_o;
  logic [3:0] pad_oe_o;
  logic [3:0] pad_sdi_i = '0;
  logic       owner_o;
  logic       busy_o;
  logic       err_o;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  qspi_pad_arb #(.TURN_CYC(2), .HOLD_MAX(8)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_i      (req_i),
    .gnt_o      (gnt_o),
    .m_sclk_i   (m_sclk_i),
    .m_csn_i    (m_csn_i),
    .m_sdo_i    (m_sdo_i),
    .m_oe_i     (m_oe_i),
    .m_sdi_o    (m_sdi_o),
    .pad_sclk_o (pad_sclk_o),
    .pad_csn_o  (pad_csn_o),
    .pad_sdo_o  (pad_sdo_o),
    .pad_oe_o   (pad_oe_o),
    .pad_sdi_i  (pad_sdi_i),
    .owner_o    (owner_o),
    .busy_o     (busy_o),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    req_i = '0;
    m_csn_i = 8'hFF;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic check_parked(input string tag);
    check({tag, "_csn"}, 32'(pad_csn_o), 32'hF);
    check({tag, "_oe"}, 32'(pad_oe_o), 32'h0);
    check({tag, "_gnt"}, 32'(gnt_o), 32'h0);
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_gnt", 32'(gnt_o), 32'h0);
    check("rst_owner", 32'(owner_o), 32'h0);
    check("rst_busy", 32'(busy_o), 32'h0);
    check("rst_err", 32'(err_o), 32'h0);
    check("rst_sclk", 32'(pad_sclk_o), 32'h0);
    check("rst_sdo", 32'(pad_sdo_o), 32'h0);
    check("rst_sdi", 32'(m_sdi_o), 32'h0);
    check_parked("rst");

    // Single request, data routing, non-owner isolation
    m_sclk_i = 2'b01; m_csn_i = 8'h0E; m_sdo_i = 8'hA5; m_oe_i = 8'hFF; pad_sdi_i = 4'hA;
    req_i = 2'b01;
    check("idle_no_gnt", 32'(gnt_o), 32'h0);
    tick();  // cycle 1
    check("s_gnt", 32'(gnt_o), 32'h1);
    check("s_owner", 32'(owner_o), 32'h0);
    check("s_busy", 32'(busy_o), 32'h1);
    check("s_csn", 32'(pad_csn_o), 32'hE);
    check("s_sdo", 32'(pad_sdo_o), 32'h5);
    check("s_oe", 32'(pad_oe_o), 32'hF);
    check("s_sclk", 32'(pad_sclk_o), 32'h1);
    check("s_sdi", 32'(m_sdi_o), 32'h0A);
    m_sclk_i = 2'b11; m_csn_i = 8'h3E; m_sdo_i = 8'h05; m_oe_i = 8'h0F;
    #1;
    check("iso_csn", 32'(pad_csn_o), 32'hE);
    check("iso_sdo", 32'(pad_sdo_o), 32'h5);
    m_sclk_i = 2'b10; m_sdo_i = 8'hF5;
    #1;
    check("iso_sclk", 32'(pad_sclk_o), 32'h0);
    check("iso_sdo2", 32'(pad_sdo_o), 32'h5);
    repeat (18) tick();  // cycle 19
    m_csn_i = 8'hFF; m_oe_i = 8'h00;
    tick();  // cycle 20
    check("s_gnt_c20", 32'(gnt_o), 32'h1);
    req_i = 2'b00;
    tick();  // cycle 21
    check_parked("s_c21");
    check("s_busy_c21", 32'(busy_o), 32'h1);
    m_oe_i = 8'hFF;
    tick();  // cycle 22
    check_parked("s_c22");
    tick();  // cycle 23
    check("s_idle_c23", 32'(busy_o), 32'h0);
    check("s_err", 32'(err_o), 32'h0);

    // Tie after reset; hold below limit must not force a release
    do_reset();
    m_csn_i = 8'hFF; m_oe_i = 8'hFF;
    req_i = 2'b11;
    tick();  // cycle 1
    check("t_gnt0", 32'(gnt_o), 32'h1);
    tick(); tick();  // cycle 3
    check("t_no_early_rel", 32'(gnt_o), 32'h1);
    req_i = 2'b10;
    tick();  // cycle 4
    check_parked("t_c4");
    tick();  // cycle 5
    check_parked("t_c5");
    tick();  // cycle 6
    check_parked("t_c6");
    tick();  // cycle 7 = drop + TURN_CYC + 2
    check("t_gnt1", 32'(gnt_o), 32'h2);
    check("t_owner1", 32'(owner_o), 32'h1);
    check("t_oe1", 32'(pad_oe_o), 32'hF);
    check("t_sdi1", 32'(m_sdi_o), 32'hA0);
    req_i = 2'b00;
    repeat (4) tick();

    // Forced release with HOLD_MAX=8
    do_reset();
    m_csn_i = 8'hFE; m_oe_i = 8'h00;
    req_i = 2'b11;
    tick();  // cycle 1
    repeat (11) tick();  // cycle 12
    check("f_hold_cs", 32'(gnt_o), 32'h1);
    m_csn_i = 8'hFF;
    tick();  // cycle 13
    check("f_release", 32'(gnt_o), 32'h0);
    check("f_rel_csn", 32'(pad_csn_o), 32'hF);
    tick(); tick();  // cycle 15, IDLE
    check("f_idle", 32'(busy_o), 32'h0);
    tick();  // cycle 16
    check("f_gnt1", 32'(gnt_o), 32'h2);
    check("f_err", 32'(err_o), 32'h0);
    req_i = 2'b00;
    repeat (4) tick();

    // Protocol error: owner drops req with csn asserted
    do_reset();
    m_csn_i = 8'hF7; m_oe_i = 8'h0F;
    req_i = 2'b01;
    tick(); tick();
    check("e_pre", 32'(err_o), 32'h0);
    req_i = 2'b00;
    tick();
    check("e_set", 32'(err_o), 32'h1);
    check_parked("e_park");
    repeat (5) tick();
    check("e_sticky", 32'(err_o), 32'h1);
    do_reset();
    check("e_clear", 32'(err_o), 32'h0);

    // Reset while master 1 owns the pads
    m_csn_i = 8'h0F; m_oe_i = 8'hF0;
    req_i = 2'b10;
    tick();
    check("r_pre_oe", 32'(pad_oe_o), 32'hF);
    check("r_pre_owner", 32'(owner_o), 32'h1);
    rst_i = 1'b1;
    tick();
    check_parked("r_mid");
    check("r_owner", 32'(owner_o), 32'h0);
    check("r_busy", 32'(busy_o), 32'h0);
    rst_i = 1'b0;
    req_i = 2'b00;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
